// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - external memory bus sequencer: address latch, timed access, capture, recover
module bus_sequencer #(
    parameter int ALE_CYCLES  = 1,
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic Clock,
    input  logic nReset,
    input  logic Req,
    input  logic Write,
    input  logic Fetch,
    input  logic Ready,
    output logic MemEn,
    output logic ALE,
    output logic nME,
    output logic nOE,
    output logic nWE,
    output logic ENB,
    output logic DOE,
    output logic IrWe,
    output logic MdrWe,
    output logic Ack,
    output logic Err,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACCESS,
        CAPTURE,
        RECOVER
    } state_t;

    localparam logic [3:0] AleLast  = 4'(ALE_CYCLES - 1);
    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);
    localparam logic [7:0] ExtLimit = 8'(TIMEOUT);

    state_t     state, nextState;
    logic [3:0] cycCnt;
    logic [7:0] extCnt;
    logic       WrQ, FetchQ, AbortQ;
    logic       minDone, timeoutHit;

    assign minDone    = (cycCnt == WaitLast);
    assign timeoutHit = (extCnt == ExtLimit);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            cycCnt <= '0;
            extCnt <= '0;
            WrQ    <= 1'b0;
            FetchQ <= 1'b0;
            AbortQ <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (Req) begin
                        WrQ    <= Write;
                        FetchQ <= Fetch;
                        cycCnt <= '0;
                        extCnt <= '0;
                        AbortQ <= 1'b0;
                    end
                end
                ADDR: begin
                    cycCnt <= (cycCnt == AleLast) ? '0 : cycCnt + 4'd1;
                end
                ACCESS: begin
                    if (!minDone) begin
                        cycCnt <= cycCnt + 4'd1;
                    end else if (!Ready) begin
                        // Extension counter stops at the limit; reaching it forces the abort capture.
                        if (timeoutHit) begin
                            AbortQ <= 1'b1;
                        end else if (extCnt != 8'hFF) begin
                            extCnt <= extCnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Req) nextState = ADDR;
            ADDR:    if (cycCnt == AleLast) nextState = ACCESS;
            ACCESS:  if (minDone && (Ready || timeoutHit)) nextState = CAPTURE;
            CAPTURE: nextState = RECOVER;
            RECOVER: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes depend only on registered state and latched mode, so reset clears them asynchronously.
    always_comb begin
        MemEn = 1'b0;
        ALE   = 1'b0;
        nME   = 1'b1;
        nOE   = 1'b1;
        nWE   = 1'b1;
        ENB   = 1'b0;
        DOE   = 1'b0;
        IrWe  = 1'b0;
        MdrWe = 1'b0;
        Ack   = 1'b0;
        Err   = 1'b0;
        Busy  = (state != IDLE);
        case (state)
            ADDR: begin
                MemEn = 1'b1;
                ALE   = 1'b1;
                nME   = 1'b0;
            end
            ACCESS: begin
                MemEn = 1'b1;
                nME   = 1'b0;
                nOE   = WrQ;
                nWE   = !WrQ;
                DOE   = WrQ;
            end
            CAPTURE: begin
                MemEn = 1'b1;
                nME   = 1'b0;
                Ack   = 1'b1;
                Err   = AbortQ;
                if (WrQ) begin
                    DOE = 1'b1;
                end else begin
                    ENB   = 1'b1;
                    nOE   = 1'b0;
                    IrWe  = FetchQ && !AbortQ;
                    MdrWe = !FetchQ && !AbortQ;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed and random checks of two bus_sequencer configurations against a cycle-index model
module tb_bus_sequencer;

    logic Clock, nReset, Req, Write, Fetch, Ready;
    logic [11:0] obs0, obs1;

    localparam int PA[2] = '{1, 4};
    localparam int PW[2] = '{2, 0};
    localparam int PT[2] = '{16, 3};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bus_sequencer dut0 (
        .Clock(Clock), .nReset(nReset), .Req(Req), .Write(Write), .Fetch(Fetch), .Ready(Ready),
        .MemEn(obs0[11]), .ALE(obs0[10]), .nME(obs0[9]), .nOE(obs0[8]), .nWE(obs0[7]),
        .ENB(obs0[6]), .DOE(obs0[5]), .IrWe(obs0[4]), .MdrWe(obs0[3]), .Ack(obs0[2]),
        .Err(obs0[1]), .Busy(obs0[0])
    );

    bus_sequencer #(.ALE_CYCLES(4), .WAIT_STATES(0), .TIMEOUT(3)) dut1 (
        .Clock(Clock), .nReset(nReset), .Req(Req), .Write(Write), .Fetch(Fetch), .Ready(Ready),
        .MemEn(obs1[11]), .ALE(obs1[10]), .nME(obs1[9]), .nOE(obs1[8]), .nWE(obs1[7]),
        .ENB(obs1[6]), .DOE(obs1[5]), .IrWe(obs1[4]), .MdrWe(obs1[3]), .Ack(obs1[2]),
        .Err(obs1[1]), .Busy(obs1[0])
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Model: position k within the current access (1 = first address cycle), capture cycle once known.
    bit mActive[2];
    int mK[2], mExt[2], mCapK[2];
    bit mWr[2], mFe[2], mAb[2];

    task automatic modelOut(input int i, output logic [11:0] e, output logic [11:0] m);
        m = 12'hFFF;
        if (!mActive[i]) begin
            e = 12'b0011_1000_0000;
        end else if (mCapK[i] != 0 && mK[i] == mCapK[i] + 1) begin
            e = 12'b0011_1000_0001;
        end else if (mCapK[i] != 0 && mK[i] == mCapK[i]) begin
            e = {1'b1, 1'b0, 1'b0, mWr[i], 1'b1, !mWr[i], mWr[i],
                 !mWr[i] && mFe[i] && !mAb[i], !mWr[i] && !mFe[i] && !mAb[i],
                 1'b1, mAb[i], 1'b1};
            m[11] = 1'b0;
        end else if (mK[i] <= PA[i]) begin
            e = 12'b1101_1000_0001;
        end else begin
            e = {1'b1, 1'b0, 1'b0, mWr[i], !mWr[i], 1'b0, mWr[i], 5'b00001};
        end
    endtask

    task automatic modelTick();
        for (int i = 0; i < 2; i++) begin
            if (!mActive[i]) begin
                if (Req) begin
                    mActive[i] = 1'b1;
                    mK[i] = 1;
                    mExt[i] = 0;
                    mCapK[i] = 0;
                    mAb[i] = 1'b0;
                    mWr[i] = Write;
                    mFe[i] = Fetch;
                end
            end else if (mCapK[i] != 0 && mK[i] == mCapK[i] + 1) begin
                mActive[i] = 1'b0;
            end else begin
                if (mCapK[i] == 0 && mK[i] >= PA[i] + PW[i] + 1) begin
                    if (Ready) begin
                        mCapK[i] = mK[i] + 1;
                    end else if (mExt[i] == PT[i]) begin
                        mCapK[i] = mK[i] + 1;
                        mAb[i] = 1'b1;
                    end else begin
                        mExt[i]++;
                    end
                end
                mK[i]++;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [11:0] e, m, o;
        for (int i = 0; i < 2; i++) begin
            modelOut(i, e, m);
            o = (i == 0) ? obs0 : obs1;
            vectors++;
            assert ((o & m) === (e & m)) else begin
                miscompares++;
                $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, i, cyc, o & m, e & m);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        if (nReset) modelTick();
        cyc++;
        @(negedge Clock);
        checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        #2 nReset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) mActive[i] = 1'b0;
        checkAll({tag, "_async"});
        @(posedge Clock);
        #2 nReset = 1'b1;
        @(negedge Clock);
        checkAll({tag, "_release"});
    endtask

    task automatic access(input bit wr, input bit fe, input int lowCnt,
                          input int expAck, input bit expErr, input string tag);
        int ackAt;
        Req = 1'b1; Write = wr; Fetch = fe; Ready = 1'b1;
        step(tag);
        Req = 1'b0; Write = 1'($urandom); Fetch = 1'($urandom);
        ackAt = 0;
        for (int c = 1; c <= 40 && ackAt == 0; c++) begin
            if (obs0[2]) begin
                ackAt = c;
            end else begin
                Ready = !(c >= 4 && c < 4 + lowCnt);
                step(tag);
            end
        end
        vectors++;
        assert (ackAt === expAck) else begin
            miscompares++;
            $error("FAIL %s_ack_cycle: observed %0d expected %0d", tag, ackAt, expAck);
        end
        vectors++;
        assert (obs0[1] === expErr) else begin
            miscompares++;
            $error("FAIL %s_err: observed %b expected %b", tag, obs0[1], expErr);
        end
        Ready = 1'b1;
        repeat (12) step({tag, "_tail"});
    endtask

    initial begin
        int last0, last1, lowRun;
        for (int i = 0; i < 2; i++) mActive[i] = 1'b0;
        nReset = 1'b0; Req = 1'b0; Write = 1'b0; Fetch = 1'b0; Ready = 1'b1;
        #1 checkAll("reset_state");
        @(posedge Clock);
        #2 nReset = 1'b1;
        @(negedge Clock);
        checkAll("after_reset");

        access(1'b0, 1'b1, 0, 5, 1'b0, "fetch_read");
        access(1'b1, 1'b0, 0, 5, 1'b0, "data_write");
        access(1'b0, 1'b0, 3, 8, 1'b0, "read_ready_low3");
        access(1'b0, 1'b0, 99, 21, 1'b1, "read_timeout");
        access(1'b1, 1'b1, 99, 21, 1'b1, "write_timeout");

        Req = 1'b1; Write = 1'b0; Fetch = 1'b1; Ready = 1'b1;
        step("midreset");
        Req = 1'b0;
        step("midreset");
        step("midreset");
        doReset("midreset");
        access(1'b0, 1'b0, 0, 5, 1'b0, "after_midreset");

        last0 = 0; last1 = 0;
        Req = 1'b1; Ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            Write = 1'($urandom); Fetch = 1'($urandom);
            step("back_to_back");
            if (obs0[2]) begin
                if (last0 > 0) begin
                    vectors++;
                    assert (cyc - last0 === 7) else begin
                        miscompares++;
                        $error("FAIL b2b_period_dut0: observed %0d expected 7", cyc - last0);
                    end
                end
                last0 = cyc;
            end
            if (obs1[2]) begin
                if (last1 > 0) begin
                    vectors++;
                    assert (cyc - last1 === 8) else begin
                        miscompares++;
                        $error("FAIL b2b_period_dut1: observed %0d expected 8", cyc - last1);
                    end
                end
                last1 = cyc;
            end
        end
        Req = 1'b0;
        repeat (10) step("b2b_tail");

        lowRun = 0;
        for (int n = 0; n < 500; n++) begin
            Req = ($urandom_range(0, 2) != 0);
            Write = 1'($urandom); Fetch = 1'($urandom);
            if (lowRun == 0 && $urandom_range(0, 7) == 0) lowRun = $urandom_range(1, 20);
            Ready = (lowRun == 0);
            if (lowRun > 0) lowRun--;
            if ($urandom_range(0, 149) == 0) doReset("random_reset");
            else step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
